// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares one single-ported main memory between the instruction-fetch unit
//   and the load/store unit. One access is outstanding at a time. Its
//   response is tracked across the memory's fixed read latency and returned
//   to the requestor that owns it. Stores into the instruction region are
//   turned into harmless reads and reported as errors. Fetch is protected
//   from starvation by a counter of consecutive LSU wins over a waiting fetch.
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   if_req_ip / if_addr_ip       fetch request and address
//   if_kill_ip                   drop the response of the in-flight fetch
//   if_gnt_op / if_rvalid_op     fetch accept / data-valid pulses
//   if_rdata_op                  fetched instruction (held between pulses)
//   lsu_req_ip, lsu_we_ip,       data request, store flag, byte enables,
//   lsu_be_ip, lsu_addr_ip,      address and store data
//   lsu_wdata_ip
//   lsu_gnt_op / lsu_rvalid_op   data accept / response-valid pulses
//   lsu_rdata_op                 load data, 0 for stores (held between pulses)
//   lsu_err_op                   rejected store, pulses with lsu_rvalid_op
//   mem_req_op, mem_we_op,       memory strobe and registered payload
//   mem_be_op, mem_addr_op,
//   mem_wdata_op
//   mem_rdata_ip                 memory read data, MEM_LATENCY after strobe

module dram_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MEM_LATENCY    = 2,
  parameter int unsigned DATA_BASE_ADDR = 128,
  parameter int unsigned STARVE_MAX     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_ip,
  input  logic [ADDR_W-1:0] if_addr_ip,
  input  logic              if_kill_ip,
  output logic              if_gnt_op,
  output logic              if_rvalid_op,
  output logic [DATA_W-1:0] if_rdata_op,
  input  logic              lsu_req_ip,
  input  logic              lsu_we_ip,
  input  logic [3:0]        lsu_be_ip,
  input  logic [ADDR_W-1:0] lsu_addr_ip,
  input  logic [DATA_W-1:0] lsu_wdata_ip,
  output logic              lsu_gnt_op,
  output logic              lsu_rvalid_op,
  output logic [DATA_W-1:0] lsu_rdata_op,
  output logic              lsu_err_op,
  output logic              mem_req_op,
  output logic              mem_we_op,
  output logic [3:0]        mem_be_op,
  output logic [ADDR_W-1:0] mem_addr_op,
  output logic [DATA_W-1:0] mem_wdata_op,
  input  logic [DATA_W-1:0] mem_rdata_ip
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LSU} owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic [STV_W-1:0] starve_cnt;
  logic             lat_store;
  logic             lat_wp;
  logic             killed;

  logic arb_any;
  logic arb_if;
  logic wp_hit;

  // LSU normally wins a tie; once fetch has lost STARVE_MAX ties in a row it wins.
  always_comb begin
    arb_any = if_req_ip || lsu_req_ip;
    arb_if  = if_req_ip && (!lsu_req_ip || (starve_cnt >= STV_W'(STARVE_MAX)));
    wp_hit  = lsu_we_ip && (lsu_addr_ip < ADDR_W'(DATA_BASE_ADDR));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      cnt           <= '0;
      starve_cnt    <= '0;
      lat_store     <= 1'b0;
      lat_wp        <= 1'b0;
      killed        <= 1'b0;
      if_gnt_op     <= 1'b0;
      if_rvalid_op  <= 1'b0;
      if_rdata_op   <= '0;
      lsu_gnt_op    <= 1'b0;
      lsu_rvalid_op <= 1'b0;
      lsu_rdata_op  <= '0;
      lsu_err_op    <= 1'b0;
      mem_req_op    <= 1'b0;
      mem_we_op     <= 1'b0;
      mem_be_op     <= '0;
      mem_addr_op   <= '0;
      mem_wdata_op  <= '0;
    end else begin
      if_gnt_op     <= 1'b0;
      if_rvalid_op  <= 1'b0;
      lsu_gnt_op    <= 1'b0;
      lsu_rvalid_op <= 1'b0;
      lsu_err_op    <= 1'b0;
      mem_req_op    <= 1'b0;
      mem_we_op     <= 1'b0;
      mem_be_op     <= '0;
      mem_addr_op   <= '0;
      mem_wdata_op  <= '0;

      case (state)
        // RESP arbitrates exactly like IDLE so a pending request issues back-to-back.
        // The grant and memory payload are registered on this edge so they appear in ISSUE.
        IDLE, RESP: begin
          killed <= 1'b0;
          if (arb_any) begin
            state      <= ISSUE;
            mem_req_op <= 1'b1;
            if (arb_if) begin
              owner       <= OWN_IF;
              if_gnt_op   <= 1'b1;
              mem_addr_op <= if_addr_ip;
              mem_be_op   <= 4'hF;
              lat_store   <= 1'b0;
              lat_wp      <= 1'b0;
              starve_cnt  <= '0;
            end else begin
              owner        <= OWN_LSU;
              lsu_gnt_op   <= 1'b1;
              mem_addr_op  <= lsu_addr_ip;
              mem_wdata_op <= lsu_wdata_ip;
              lat_store    <= lsu_we_ip;
              lat_wp       <= wp_hit;
              if (wp_hit) begin
                mem_we_op <= 1'b0;
                mem_be_op <= '0;
              end else if (lsu_we_ip) begin
                mem_we_op <= 1'b1;
                mem_be_op <= lsu_be_ip;
              end else begin
                mem_be_op <= 4'hF;
              end
              if (!if_req_ip) begin
                starve_cnt <= '0;
              end else if (starve_cnt < STV_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + STV_W'(1);
              end
            end
          end else begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
          end
        end

        ISSUE: begin
          cnt   <= CNT_W'(MEM_LATENCY - 1);
          state <= WAIT;
          if ((owner == OWN_IF) && if_kill_ip) begin
            killed <= 1'b1;
          end
        end

        WAIT: begin
          if ((owner == OWN_IF) && if_kill_ip) begin
            killed <= 1'b1;
          end
          if (cnt == '0) begin
            state <= RESP;
            if (owner == OWN_IF) begin
              // A kill seen on this same edge still suppresses the response.
              if (!(killed || if_kill_ip)) begin
                if_rvalid_op <= 1'b1;
                if_rdata_op  <= mem_rdata_ip;
              end
            end else if (owner == OWN_LSU) begin
              lsu_rvalid_op <= 1'b1;
              lsu_rdata_op  <= lat_store ? '0 : mem_rdata_ip;
              lsu_err_op    <= lat_wp;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter
//   Directed bench for dram_port_arbiter with a fixed-latency memory model
//   and scoreboard queues for grant order, memory issues and responses.

module tb_dram_port_arbiter;

  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_ip = 1'b0;
  logic [31:0] if_addr_ip = '0;
  logic        if_kill_ip = 1'b0;
  logic        if_gnt_op;
  logic        if_rvalid_op;
  logic [31:0] if_rdata_op;
  logic        lsu_req_ip = 1'b0;
  logic        lsu_we_ip = 1'b0;
  logic [3:0]  lsu_be_ip = '0;
  logic [31:0] lsu_addr_ip = '0;
  logic [31:0] lsu_wdata_ip = '0;
  logic        lsu_gnt_op;
  logic        lsu_rvalid_op;
  logic [31:0] lsu_rdata_op;
  logic        lsu_err_op;
  logic        mem_req_op;
  logic        mem_we_op;
  logic [3:0]  mem_be_op;
  logic [31:0] mem_addr_op;
  logic [31:0] mem_wdata_op;
  logic [31:0] mem_rdata_ip;

  dram_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MEM_LATENCY(LAT),
    .DATA_BASE_ADDR(128),
    .STARVE_MAX(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .if_req_ip(if_req_ip),
    .if_addr_ip(if_addr_ip),
    .if_kill_ip(if_kill_ip),
    .if_gnt_op(if_gnt_op),
    .if_rvalid_op(if_rvalid_op),
    .if_rdata_op(if_rdata_op),
    .lsu_req_ip(lsu_req_ip),
    .lsu_we_ip(lsu_we_ip),
    .lsu_be_ip(lsu_be_ip),
    .lsu_addr_ip(lsu_addr_ip),
    .lsu_wdata_ip(lsu_wdata_ip),
    .lsu_gnt_op(lsu_gnt_op),
    .lsu_rvalid_op(lsu_rvalid_op),
    .lsu_rdata_op(lsu_rdata_op),
    .lsu_err_op(lsu_err_op),
    .mem_req_op(mem_req_op),
    .mem_we_op(mem_we_op),
    .mem_be_op(mem_be_op),
    .mem_addr_op(mem_addr_op),
    .mem_wdata_op(mem_wdata_op),
    .mem_rdata_ip(mem_rdata_ip)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } issue_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } lrsp_t;

  issue_t      issue_q[$];
  logic [1:0]  gnt_q[$];
  logic [31:0] if_q[$];
  lrsp_t       lsu_q[$];

  int errors = 0;
  int checks = 0;
  logic [31:0] last_if = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: data for an accepted strobe is valid LAT cycles later, garbage otherwise.
  logic [LAT-1:0] pv = '0;
  logic [31:0]    pa [LAT];
  always @(posedge clock) begin
    pv[0] <= mem_req_op;
    pa[0] <= mem_addr_op;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_rdata_ip = pv[LAT-1] ? mem_val(pa[LAT-1]) : 32'hBAD0_BAD0;

  // Scoreboard
  always @(negedge clock) begin
    if (reset) begin
      logic [1:0] g;
      issue_t     e;
      lrsp_t      r;
      chk("gnt_excl", {63'd0, if_gnt_op & lsu_gnt_op}, 64'd0);
      chk("err_pulse", {63'd0, lsu_err_op & ~lsu_rvalid_op}, 64'd0);
      if (if_gnt_op || lsu_gnt_op) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", {62'd0, lsu_gnt_op, if_gnt_op}, 64'd0);
        else begin
          g = gnt_q.pop_front();
          chk("gnt_order", {62'd0, lsu_gnt_op, if_gnt_op}, {62'd0, g});
        end
      end
      if (mem_req_op) begin
        if (issue_q.size() == 0) chk("issue_unexpected", {63'd0, mem_req_op}, 64'd0);
        else begin
          e = issue_q.pop_front();
          chk("issue_addr", {32'd0, mem_addr_op}, {32'd0, e.addr});
          chk("issue_we_be", {59'd0, mem_we_op, mem_be_op}, {59'd0, e.we, e.be});
          if (e.we) chk("issue_wdata", {32'd0, mem_wdata_op}, {32'd0, e.wdata});
        end
      end
      if (if_rvalid_op) begin
        if (if_q.size() == 0) chk("if_rvalid_unexpected", {63'd0, if_rvalid_op}, 64'd0);
        else chk("if_rdata", {32'd0, if_rdata_op}, {32'd0, if_q.pop_front()});
      end
      if (lsu_rvalid_op) begin
        if (lsu_q.size() == 0) chk("lsu_rvalid_unexpected", {63'd0, lsu_rvalid_op}, 64'd0);
        else begin
          r = lsu_q.pop_front();
          chk("lsu_rdata_err", {31'd0, lsu_rdata_op, lsu_err_op}, {31'd0, r.data, r.err});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {53'd0, if_gnt_op, if_rvalid_op, lsu_gnt_op, lsu_rvalid_op,
        lsu_err_op, mem_req_op, mem_we_op, mem_be_op}, 64'd0);
    chk({tag, "_rdata"}, {if_rdata_op, lsu_rdata_op}, 64'd0);
    chk({tag, "_mem"}, {mem_addr_op, mem_wdata_op}, 64'd0);
  endtask

  task automatic do_if(input logic [31:0] addr);
    gnt_q.push_back(2'b01);
    issue_q.push_back('{addr: addr, we: 1'b0, be: 4'hF, wdata: 32'h0});
    if_q.push_back(mem_val(addr));
    @(posedge clock); #1;
    if_req_ip  = 1'b1;
    if_addr_ip = addr;
    @(negedge clock);
    chk("if_gnt_c0", {63'd0, if_gnt_op}, 64'd0);
    @(negedge clock);
    chk("if_gnt_c1", {63'd0, if_gnt_op}, 64'd1);
    chk("if_mem_c1", {31'd0, mem_req_op, mem_addr_op}, {31'd0, 1'b1, addr});
    if_req_ip = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("if_rvalid_early", {63'd0, if_rvalid_op}, 64'd0);
    end
    @(negedge clock);
    chk("if_rvalid_c4", {63'd0, if_rvalid_op}, 64'd1);
    last_if = mem_val(addr);
  endtask

  task automatic do_lsu(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic wp;
    wp = we && (addr < 32'd128);
    gnt_q.push_back(2'b10);
    if (!we)     issue_q.push_back('{addr: addr, we: 1'b0, be: 4'hF, wdata: 32'h0});
    else if (wp) issue_q.push_back('{addr: addr, we: 1'b0, be: 4'h0, wdata: wdata});
    else         issue_q.push_back('{addr: addr, we: 1'b1, be: be, wdata: wdata});
    lsu_q.push_back(we ? '{data: 32'h0, err: wp} : '{data: mem_val(addr), err: 1'b0});
    @(posedge clock); #1;
    lsu_req_ip   = 1'b1;
    lsu_we_ip    = we;
    lsu_be_ip    = be;
    lsu_addr_ip  = addr;
    lsu_wdata_ip = wdata;
    @(negedge clock);
    chk("lsu_gnt_c0", {63'd0, lsu_gnt_op}, 64'd0);
    @(negedge clock);
    chk("lsu_gnt_c1", {63'd0, lsu_gnt_op}, 64'd1);
    lsu_req_ip = 1'b0;
    repeat (2) @(negedge clock);
    @(negedge clock);
    chk("lsu_rvalid_c4", {62'd0, lsu_rvalid_op, lsu_err_op}, {62'd0, 1'b1, wp});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    // 1: single fetch, timing and held rdata
    do_if(32'h10);
    @(negedge clock);
    chk("if_rvalid_pulse", {63'd0, if_rvalid_op}, 64'd0);
    chk("if_rdata_hold", {32'd0, if_rdata_op}, {32'd0, 32'h0050_0093});

    // 2: simultaneous requests, LSU first then IF back-to-back
    gnt_q.push_back(2'b10);
    gnt_q.push_back(2'b01);
    issue_q.push_back('{addr: 32'h200, we: 1'b0, be: 4'hF, wdata: 32'h0});
    issue_q.push_back('{addr: 32'h20, we: 1'b0, be: 4'hF, wdata: 32'h0});
    lsu_q.push_back('{data: mem_val(32'h200), err: 1'b0});
    if_q.push_back(mem_val(32'h20));
    @(posedge clock); #1;
    lsu_req_ip = 1'b1; lsu_we_ip = 1'b0; lsu_addr_ip = 32'h200;
    if_req_ip = 1'b1; if_addr_ip = 32'h20;
    @(negedge clock);
    @(negedge clock);
    chk("tie_gnt_c1", {62'd0, lsu_gnt_op, if_gnt_op}, 64'd2);
    lsu_req_ip = 1'b0;
    repeat (2) @(negedge clock);
    @(negedge clock);
    chk("tie_lsu_rvalid_c4", {62'd0, lsu_rvalid_op, if_gnt_op}, 64'd2);
    @(negedge clock);
    chk("tie_if_gnt_c5", {63'd0, if_gnt_op}, 64'd1);
    if_req_ip = 1'b0;
    repeat (2) @(negedge clock);
    @(negedge clock);
    chk("tie_if_rvalid_c8", {63'd0, if_rvalid_op}, 64'd1);
    last_if = mem_val(32'h20);

    // 3: both held high; IF wins every fourth arbitration
    for (int g = 0; g < 8; g++) begin
      if (g % 4 == 3) begin
        gnt_q.push_back(2'b01);
        issue_q.push_back('{addr: 32'h30, we: 1'b0, be: 4'hF, wdata: 32'h0});
        if_q.push_back(mem_val(32'h30));
      end else begin
        gnt_q.push_back(2'b10);
        issue_q.push_back('{addr: 32'h300, we: 1'b0, be: 4'hF, wdata: 32'h0});
        lsu_q.push_back('{data: mem_val(32'h300), err: 1'b0});
      end
    end
    @(posedge clock); #1;
    lsu_req_ip = 1'b1; lsu_we_ip = 1'b0; lsu_addr_ip = 32'h300;
    if_req_ip = 1'b1; if_addr_ip = 32'h30;
    @(negedge clock);
    for (int g = 0; g < 8; g++) begin
      @(negedge clock);
      chk("starve_gnt", {62'd0, lsu_gnt_op, if_gnt_op}, (g % 4 == 3) ? 64'd1 : 64'd2);
      if (g < 7) repeat (3) @(negedge clock);
    end
    lsu_req_ip = 1'b0;
    if_req_ip  = 1'b0;
    repeat (2) @(negedge clock);
    @(negedge clock);
    chk("starve_last_rvalid", {63'd0, if_rvalid_op}, 64'd1);
    last_if = mem_val(32'h30);

    // 4: write protection around the data-region boundary, then a data-region load
    do_lsu(1'b1, 4'b0011, 32'h40, 32'h1122_3344);
    do_lsu(1'b1, 4'b0011, 32'h80, 32'h5566_7788);
    do_lsu(1'b1, 4'b1111, 32'h7C, 32'h99AA_BBCC);
    do_lsu(1'b0, 4'b0000, 32'h84, 32'h0);
    @(negedge clock);
    chk("lsu_rdata_hold", {32'd0, lsu_rdata_op}, {32'd0, mem_val(32'h84)});

    // 5: kill during WAIT; pending LSU still granted from RESP
    gnt_q.push_back(2'b01);
    gnt_q.push_back(2'b10);
    issue_q.push_back('{addr: 32'h50, we: 1'b0, be: 4'hF, wdata: 32'h0});
    issue_q.push_back('{addr: 32'h210, we: 1'b0, be: 4'hF, wdata: 32'h0});
    lsu_q.push_back('{data: mem_val(32'h210), err: 1'b0});
    @(posedge clock); #1;
    if_req_ip = 1'b1; if_addr_ip = 32'h50;
    @(negedge clock);
    @(negedge clock);
    chk("kill_if_gnt_c1", {63'd0, if_gnt_op}, 64'd1);
    if_req_ip = 1'b0;
    @(negedge clock);
    lsu_req_ip = 1'b1; lsu_we_ip = 1'b0; lsu_addr_ip = 32'h210;
    if_kill_ip = 1'b1;
    @(negedge clock);
    if_kill_ip = 1'b0;
    @(negedge clock);
    chk("kill_no_rvalid_c4", {63'd0, if_rvalid_op}, 64'd0);
    chk("kill_rdata_hold", {32'd0, if_rdata_op}, {32'd0, last_if});
    @(negedge clock);
    chk("kill_lsu_gnt_c5", {63'd0, lsu_gnt_op}, 64'd1);
    lsu_req_ip = 1'b0;
    repeat (2) @(negedge clock);
    @(negedge clock);
    chk("kill_lsu_rvalid_c8", {63'd0, lsu_rvalid_op}, 64'd1);

    // 6: reset during WAIT, then a clean fetch
    gnt_q.push_back(2'b01);
    issue_q.push_back('{addr: 32'h60, we: 1'b0, be: 4'hF, wdata: 32'h0});
    @(posedge clock); #1;
    if_req_ip = 1'b1; if_addr_ip = 32'h60;
    @(negedge clock);
    @(negedge clock);
    chk("rst_if_gnt_c1", {63'd0, if_gnt_op}, 64'd1);
    if_req_ip = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    do_if(32'h70);
    repeat (4) @(negedge clock);

    chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    chk("issue_q_empty", 64'(issue_q.size()), 64'd0);
    chk("if_q_empty", 64'(if_q.size()), 64'd0);
    chk("lsu_q_empty", 64'(lsu_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
